// File: rtl/divider_seq_nbit_pkg.sv
// divider_seq_nbit_pkg: state encoding and default width for the sequential divider
package divider_seq_nbit_pkg;
  localparam int N_DEFAULT = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/adder_subtractor_nbit.sv
// adder_subtractor_nbit: ripple add/subtract; add_n=1 computes a-b, c_out=1 means no borrow
module adder_subtractor_nbit #(
  parameter int n = 4
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         add_n,
  output logic [n-1:0] s,
  output logic         c_out
);
  assign {c_out, s} = {1'b0, a} + {1'b0, b ^ {n{add_n}}} + {{n{1'b0}}, add_n};
endmodule

// File: rtl/divider_seq_nbit.sv
// divider_seq_nbit: n-cycle restoring unsigned divider with registered results
module divider_seq_nbit
  import divider_seq_nbit_pkg::*;
#(
  parameter int n = N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
  output logic         ready,
  output logic         done,
  output logic [n-1:0] quotient,
  output logic [n-1:0] remainder,
  output logic         div_by_zero
);
  localparam int CW = $clog2(n + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [n:0] p, p_shift, t;
  logic [n-1:0] dvd, dvs;
  logic c_out, last;
  // dvd shifts dividend bits out at the top and quotient bits in at the bottom
  assign p_shift = {p[n-1:0], dvd[n-1]};
  assign last = cnt == CW'(n - 1);
  adder_subtractor_nbit #(.n(n + 1)) u_addsub (
    .a(p_shift),
    .b({1'b0, dvs}),
    .add_n(1'b1),
    .s(t),
    .c_out(c_out)
  );
  always_comb begin
    state_n = state == IDLE ? (start ? (|divisor ? RUN : DONE) : IDLE) :
              state == RUN  ? (last ? DONE : RUN) : IDLE;
    ready = state == IDLE;
    done = state == DONE;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      p <= '0;
      dvd <= '0;
      dvs <= '0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else if (state == IDLE && start) begin
      cnt <= '0;
      p <= '0;
      dvd <= dividend;
      dvs <= divisor;
      div_by_zero <= ~|divisor;
      if (~|divisor) begin
        quotient <= '1;
        remainder <= dividend;
      end
    end else if (state == RUN) begin
      p <= c_out ? t : p_shift;
      dvd <= {dvd[n-2:0], c_out};
      cnt <= cnt + CW'(1);
      if (last) begin
        quotient <= {dvd[n-2:0], c_out};
        remainder <= c_out ? t[n-1:0] : p_shift[n-1:0];
      end
    end
  end
endmodule
